// File: rtl/vram_wr_arbiter.sv
// rtl/vram_wr_arbiter.sv - VRAM write-port arbiter (renderer/host/clear sweep); VRAM_ARB_RR_EN selects round-robin
module vram_wr_arbiter #(
  parameter int DW       = 24,
  parameter int AW       = 16,
  parameter int NPIX     = 53760,
  parameter int MAX_WAIT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ren_valid,
  output logic          ren_ready,
  input  logic [AW-1:0] ren_adr,
  input  logic [DW-1:0] ren_d,
  input  logic          host_valid,
  output logic          host_ready,
  input  logic [AW-1:0] host_adr,
  input  logic [DW-1:0] host_d,
  output logic          host_err,
  input  logic          clr_start,
  input  logic [DW-1:0] clr_color,
  output logic          clr_busy,
  output logic          clr_done,
  output logic          vram_we,
  output logic [AW-1:0] vram_wadr,
  output logic [DW-1:0] vram_d
);

  typedef enum logic {ARB = 1'b0, CLEAR = 1'b1} state_t;

  localparam logic [AW-1:0] LAST_ADR = AW'(NPIX - 1);
  localparam logic [AW-1:0] NPIX_ADR = AW'(NPIX);

  state_t        r_state;
  state_t        w_next_state;
  logic [AW-1:0] r_clr_adr;
  logic [DW-1:0] r_clr_color;
  logic          w_ren_xfer;
  logic          w_host_xfer;
  logic          w_host_oor;
  logic          w_clr_last;

`ifdef VRAM_ARB_RR_EN
  logic r_last_host;
`else
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);
  logic [WW-1:0] r_wait;
  logic          w_host_pri;
  assign w_host_pri = (r_wait == WAIT_MAX);
`endif

  assign w_ren_xfer  = ren_valid && ren_ready;
  assign w_host_xfer = host_valid && host_ready;
  assign w_host_oor  = (host_adr >= NPIX_ADR);
  assign w_clr_last  = (r_clr_adr == LAST_ADR);
  assign clr_busy    = (r_state == CLEAR);

  // Grant selection and next-state; grants are held off during reset and while clearing
  always_comb begin
    w_next_state = r_state;
    ren_ready    = 1'b0;
    host_ready   = 1'b0;
    if (r_state == ARB) begin
      if (reset) begin
`ifdef VRAM_ARB_RR_EN
        if (ren_valid && host_valid) begin
          ren_ready  = r_last_host;
          host_ready = !r_last_host;
        end else begin
          ren_ready  = ren_valid;
          host_ready = host_valid;
        end
`else
        ren_ready  = ren_valid && !(w_host_pri && host_valid);
        host_ready = host_valid && !(ren_valid && !(w_host_pri && host_valid));
`endif
      end
      if (clr_start) begin
        w_next_state = CLEAR;
      end
    end else if (w_clr_last) begin
      w_next_state = ARB;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= ARB;
    else        r_state <= w_next_state;
  end

  // Clear sweep address and latched fill colour
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_clr_adr   <= '0;
      r_clr_color <= '0;
    end else if (r_state == CLEAR) begin
      r_clr_adr <= w_clr_last ? '0 : r_clr_adr + 1'b1;
    end else if (clr_start) begin
      r_clr_adr   <= '0;
      r_clr_color <= clr_color;
    end
  end

`ifdef VRAM_ARB_RR_EN
  // Remember who was granted last so contention alternates
  always_ff @(posedge clk) begin
    if (!reset)           r_last_host <= 1'b1;
    else if (w_ren_xfer)  r_last_host <= 1'b0;
    else if (w_host_xfer) r_last_host <= 1'b1;
  end
`else
  // Host starvation counter; frozen while clearing
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wait <= '0;
    end else if (r_state == ARB) begin
      if (host_valid && !host_ready) begin
        if (r_wait != WAIT_MAX) r_wait <= r_wait + 1'b1;
      end else begin
        r_wait <= '0;
      end
    end
  end
`endif

  // Registered VRAM write bus and status pulses
  always_ff @(posedge clk) begin
    if (!reset) begin
      vram_we   <= 1'b0;
      vram_wadr <= '0;
      vram_d    <= '0;
      host_err  <= 1'b0;
      clr_done  <= 1'b0;
    end else begin
      vram_we  <= 1'b0;
      host_err <= 1'b0;
      clr_done <= 1'b0;
      if (r_state == CLEAR) begin
        vram_we   <= 1'b1;
        vram_wadr <= r_clr_adr;
        vram_d    <= r_clr_color;
        clr_done  <= w_clr_last;
      end else if (w_ren_xfer) begin
        vram_we   <= 1'b1;
        vram_wadr <= ren_adr;
        vram_d    <= ren_d;
      end else if (w_host_xfer) begin
        if (w_host_oor) begin
          host_err <= 1'b1;
        end else begin
          vram_we   <= 1'b1;
          vram_wadr <= host_adr;
          vram_d    <= host_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_vram_wr_arbiter.sv
// tb/tb_vram_wr_arbiter.sv - scoreboard bench for vram_wr_arbiter
module tb_vram_wr_arbiter;

  localparam int DW       = 24;
  localparam int AW       = 16;
  localparam int NPIX     = 53760;
  localparam int MAX_WAIT = 15;

  logic          clk;
  logic          reset;
  logic          ren_valid;
  logic          ren_ready;
  logic [AW-1:0] ren_adr;
  logic [DW-1:0] ren_d;
  logic          host_valid;
  logic          host_ready;
  logic [AW-1:0] host_adr;
  logic [DW-1:0] host_d;
  logic          host_err;
  logic          clr_start;
  logic [DW-1:0] clr_color;
  logic          clr_busy;
  logic          clr_done;
  logic          vram_we;
  logic [AW-1:0] vram_wadr;
  logic [DW-1:0] vram_d;

  vram_wr_arbiter #(.DW(DW), .AW(AW), .NPIX(NPIX), .MAX_WAIT(MAX_WAIT)) dut (
    .clk        (clk),
    .reset      (reset),
    .ren_valid  (ren_valid),
    .ren_ready  (ren_ready),
    .ren_adr    (ren_adr),
    .ren_d      (ren_d),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .host_adr   (host_adr),
    .host_d     (host_d),
    .host_err   (host_err),
    .clr_start  (clr_start),
    .clr_color  (clr_color),
    .clr_busy   (clr_busy),
    .clr_done   (clr_done),
    .vram_we    (vram_we),
    .vram_wadr  (vram_wadr),
    .vram_d     (vram_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          we;
    logic          err;
    logic          done;
    logic          busy;
    logic          bus;
    logic [AW-1:0] adr;
    logic [DW-1:0] d;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int            m_state;
  int            m_wait;
  logic          m_last_host;
  int            m_clr_adr;
  logic [DW-1:0] m_color;
  int            ren_grants;
  int            host_grants;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cycle();
    logic er, eh;
    exp_t e;
    #1;
    er = 1'b0;
    eh = 1'b0;
    if (reset && m_state == 0) begin
`ifdef VRAM_ARB_RR_EN
      if (ren_valid && host_valid) begin
        er = m_last_host;
        eh = !m_last_host;
      end else begin
        er = ren_valid;
        eh = host_valid;
      end
`else
      if (host_valid && m_wait == MAX_WAIT) eh = 1'b1;
      else if (ren_valid)                   er = 1'b1;
      else                                  eh = host_valid;
`endif
    end
    chk("ren_ready", 32'(ren_ready), 32'(er));
    chk("host_ready", 32'(host_ready), 32'(eh));
    if (er) ren_grants++;
    if (eh) host_grants++;
    e = '0;
    if (!reset) begin
      e.bus       = 1'b1;
      m_state     = 0;
      m_wait      = 0;
      m_last_host = 1'b1;
      m_clr_adr   = 0;
    end else if (m_state == 1) begin
      e.we   = 1'b1;
      e.bus  = 1'b1;
      e.adr  = AW'(m_clr_adr);
      e.d    = m_color;
      e.done = (m_clr_adr == NPIX - 1);
      if (e.done) begin
        m_state   = 0;
        m_clr_adr = 0;
      end else begin
        m_clr_adr++;
      end
    end else begin
      if (er) begin
        e.we = 1'b1; e.bus = 1'b1; e.adr = ren_adr; e.d = ren_d;
      end else if (eh) begin
        if (int'(host_adr) >= NPIX) e.err = 1'b1;
        else begin
          e.we = 1'b1; e.bus = 1'b1; e.adr = host_adr; e.d = host_d;
        end
      end
      if (host_valid && !eh) m_wait = (m_wait == MAX_WAIT) ? MAX_WAIT : m_wait + 1;
      else                   m_wait = 0;
      if (er) m_last_host = 1'b0;
      if (eh) m_last_host = 1'b1;
      if (clr_start) begin
        m_state   = 1;
        m_color   = clr_color;
        m_clr_adr = 0;
      end
    end
    e.busy = (m_state == 1);
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    chk("vram_we", 32'(vram_we), 32'(e.we));
    chk("host_err", 32'(host_err), 32'(e.err));
    chk("clr_done", 32'(clr_done), 32'(e.done));
    chk("clr_busy", 32'(clr_busy), 32'(e.busy));
    if (e.bus) begin
      chk("vram_wadr", 32'(vram_wadr), 32'(e.adr));
      chk("vram_d", 32'(vram_d), 32'(e.d));
    end
  endtask

  task automatic idle_inputs();
    ren_valid = 0; host_valid = 0; clr_start = 0;
  endtask

  initial begin
    reset = 0; ren_valid = 1; host_valid = 1; clr_start = 0;
    ren_adr = 16'h0001; ren_d = 24'h111111; host_adr = 16'h0002; host_d = 24'h222222;
    clr_color = 24'hABCDEF;
    m_state = 0; m_wait = 0; m_last_host = 1'b1; m_clr_adr = 0; m_color = '0;
    ren_grants = 0; host_grants = 0;
    @(negedge clk);
    // reset held low with requests pending
    repeat (2) cycle();
    reset = 1;
    idle_inputs();
    cycle();

    // renderer only
    ren_valid = 1; ren_adr = 16'h0010; ren_d = 24'hFFFFFF;
    cycle();
    for (int i = 0; i < 3; i++) begin
      ren_adr = AW'(16'h0100 + i); ren_d = DW'($urandom);
      cycle();
    end
    idle_inputs();
    cycle();

    // host only, including the last valid pixel
    host_valid = 1; host_adr = 16'h1234; host_d = 24'h00FF00;
    cycle();
    host_adr = AW'(NPIX - 1); host_d = 24'h0000FF;
    cycle();
    idle_inputs();

    // continuous contention
    ren_grants = 0; host_grants = 0;
    ren_valid = 1; host_valid = 1;
    for (int i = 0; i < 40; i++) begin
      ren_adr = AW'(i); ren_d = DW'(24'h100000 + i);
      host_adr = AW'(16'h2000 + i); host_d = DW'(24'h200000 + i);
      cycle();
    end
`ifdef VRAM_ARB_RR_EN
    chk("rr_host_grants", 32'(host_grants), 32'd20);
`else
    chk("fp_host_grants", 32'(host_grants), 32'd2);
`endif
    idle_inputs();
    cycle();

    // random request mix
    for (int i = 0; i < 80; i++) begin
      ren_valid  = ($urandom_range(0, 3) != 0);
      host_valid = ($urandom_range(0, 3) != 0);
      ren_adr  = AW'($urandom_range(0, NPIX - 1)); ren_d  = DW'($urandom);
      host_adr = AW'($urandom_range(0, NPIX - 1)); host_d = DW'($urandom);
      cycle();
    end
    idle_inputs();
    cycle();

    // host out of range
    host_valid = 1; host_adr = AW'(NPIX); host_d = 24'hDEAD00;
    cycle();
    idle_inputs();
    cycle();
    host_valid = 1; host_adr = 16'hFFFF;
    cycle();
    idle_inputs();
    cycle();

    // full clear sweep with the renderer requesting throughout
    ren_valid = 1; ren_adr = 16'h0042; ren_d = 24'h424242;
    clr_color = 24'h000000; clr_start = 1;
    cycle();
    clr_start = 0; clr_color = 24'h777777;
    for (int i = 0; i < 500; i++) cycle();
    clr_start = 1;
    cycle();
    clr_start = 0;
    while (m_state == 1) cycle();
    repeat (3) cycle();

    // reset during a sweep
    idle_inputs();
    clr_color = 24'h123456; clr_start = 1;
    cycle();
    clr_start = 0;
    while (m_clr_adr != 100) cycle();
    reset = 0;
    cycle();
    reset = 1;
    cycle();
    ren_valid = 1; ren_adr = 16'h0777; ren_d = 24'h5A5A5A;
    repeat (2) cycle();
    idle_inputs();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
